// File: rtl/bellek_hakemi_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, requester ids and default bus widths.
package bellek_hakemi_pkg;

  localparam int VARSAYILAN_VERI_BIT  = 32;
  localparam int VARSAYILAN_ADRES_BIT = 32;

  // Requester ids; also used as the round-robin owner value.
  localparam logic ISTEKCI_ISLEMCI   = 1'b0;
  localparam logic ISTEKCI_YUKLEYICI = 1'b1;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    ERISIM = 2'd1,
    BEKLE  = 2'd2
  } durum_t;

endpackage

// File: rtl/bellek_hakemi_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// slave: arbiter view; master: requester/memory side view.
interface bellek_hakemi_if
  import bellek_hakemi_pkg::*;
#(
  parameter int VERI_BIT  = VARSAYILAN_VERI_BIT,
  parameter int ADRES_BIT = VARSAYILAN_ADRES_BIT
);

  logic                 m0_istek;
  logic                 m0_yaz;
  logic [ADRES_BIT-1:0] m0_adres;
  logic [VERI_BIT-1:0]  m0_yaz_veri;
  logic                 m0_hazir;
  logic [VERI_BIT-1:0]  m0_oku_veri;
  logic                 m0_oku_gecerli;

  logic                 m1_istek;
  logic                 m1_yaz;
  logic [ADRES_BIT-1:0] m1_adres;
  logic [VERI_BIT-1:0]  m1_yaz_veri;
  logic                 m1_hazir;
  logic [VERI_BIT-1:0]  m1_oku_veri;
  logic                 m1_oku_gecerli;
  logic                 m1_hata;

  logic [ADRES_BIT-1:0] bellek_adres;
  logic [VERI_BIT-1:0]  bellek_yaz_veri;
  logic                 bellek_yaz;
  logic [VERI_BIT-1:0]  bellek_oku_veri;

  modport slave (
    input  m0_istek, m0_yaz, m0_adres, m0_yaz_veri,
    output m0_hazir, m0_oku_veri, m0_oku_gecerli,
    input  m1_istek, m1_yaz, m1_adres, m1_yaz_veri,
    output m1_hazir, m1_oku_veri, m1_oku_gecerli, m1_hata,
    output bellek_adres, bellek_yaz_veri, bellek_yaz,
    input  bellek_oku_veri
  );

  modport master (
    output m0_istek, m0_yaz, m0_adres, m0_yaz_veri,
    input  m0_hazir, m0_oku_veri, m0_oku_gecerli,
    output m1_istek, m1_yaz, m1_adres, m1_yaz_veri,
    input  m1_hazir, m1_oku_veri, m1_oku_gecerli, m1_hata,
    input  bellek_adres, bellek_yaz_veri, bellek_yaz,
    output bellek_oku_veri
  );

endinterface

// File: rtl/bellek_hakemi_hakem_rr_secici.sv
// Combinational two-way round-robin pick. On a tie the requester that did
// not own the bus last time wins.
module hakem_rr_secici (
  input  logic istek0,
  input  logic istek1,
  input  logic son_sahip,
  output logic secim_id,
  output logic secim_gecerli
);

  assign secim_gecerli = istek0 | istek1;
  // Tie goes to the non-owner; otherwise the single requester.
  assign secim_id      = (istek0 && istek1) ? ~son_sahip : istek1;

endmodule

// File: rtl/bellek_hakemi.sv
// bellek_hakemi: shares one memory port between the core (requester 0)
// and the loader/DMA (requester 1). One transaction at a time:
// BOSTA (accept) -> ERISIM (1 access cycle) -> optional BEKLE (read latency).
// Optional write protection for requester 1: define BELLEK_HAKEMI_KORUMA_EN.
module bellek_hakemi
  import bellek_hakemi_pkg::*;
#(
  parameter int                   VERI_BIT     = VARSAYILAN_VERI_BIT,
  parameter int                   ADRES_BIT    = VARSAYILAN_ADRES_BIT,
  parameter int                   OKU_GECIKME  = 0,
  parameter int                   SAYAC_BIT    = 4,
  parameter logic [ADRES_BIT-1:0] KORUMA_TABAN = 32'h8000_0000,
  parameter logic [ADRES_BIT-1:0] KORUMA_BOYUT = 32'h0000_1000
) (
  input logic            clk,
  input logic            rst,
  bellek_hakemi_if.slave bus
);

  localparam logic [ADRES_BIT:0] KORUMA_SON = {1'b0, KORUMA_TABAN} + {1'b0, KORUMA_BOYUT};

  durum_t               durum;
  logic                 son_sahip;
  logic                 sahip;
  logic                 yaz_reg;
  logic [SAYAC_BIT-1:0] sayac;
  logic [VERI_BIT-1:0]  oku_veri_reg [2];
  logic [1:0]           gecerli_reg;
  logic                 bellek_yaz_reg;
  logic                 hata_reg;
  logic [ADRES_BIT-1:0] adres_reg;
  logic [VERI_BIT-1:0]  yaz_veri_reg;

  logic                 secim_id;
  logic                 secim_gecerli;
  logic                 kabul;
  logic                 sec_yaz;
  logic [ADRES_BIT-1:0] sec_adres;
  logic [VERI_BIT-1:0]  sec_veri;
  logic                 pencere_icinde;
  logic                 korumali;

  hakem_rr_secici u_secici (
    .istek0        (bus.m0_istek),
    .istek1        (bus.m1_istek),
    .son_sahip     (son_sahip),
    .secim_id      (secim_id),
    .secim_gecerli (secim_gecerli)
  );

  // A grant only exists while idle and out of reset.
  assign kabul = rst && (durum == BOSTA) && secim_gecerli;

  // Route the granted requester's transaction fields.
  always_comb begin
    sec_yaz   = bus.m0_yaz;
    sec_adres = bus.m0_adres;
    sec_veri  = bus.m0_yaz_veri;
    if (secim_id == ISTEKCI_YUKLEYICI) begin
      sec_yaz   = bus.m1_yaz;
      sec_adres = bus.m1_adres;
      sec_veri  = bus.m1_yaz_veri;
    end
  end

  assign pencere_icinde = ({1'b0, sec_adres} >= {1'b0, KORUMA_TABAN}) &&
                          ({1'b0, sec_adres} <  KORUMA_SON);

`ifdef BELLEK_HAKEMI_KORUMA_EN
  // Loader writes into the protected window are dropped and flagged.
  assign korumali = sec_yaz && (secim_id == ISTEKCI_YUKLEYICI) && pencere_icinde;
`else
  // Window decode stays elaborated but never gates a write in this build.
  assign korumali = pencere_icinde & 1'b0;
`endif

  // Arbiter FSM: accept, one access cycle, optional latency wait, capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum           <= BOSTA;
      son_sahip       <= ISTEKCI_YUKLEYICI;
      sahip           <= ISTEKCI_ISLEMCI;
      yaz_reg         <= 1'b0;
      sayac           <= '0;
      oku_veri_reg[0] <= '0;
      oku_veri_reg[1] <= '0;
      gecerli_reg     <= 2'b00;
      bellek_yaz_reg  <= 1'b0;
      hata_reg        <= 1'b0;
      adres_reg       <= '0;
      yaz_veri_reg    <= '0;
    end else begin
      bellek_yaz_reg <= 1'b0;
      hata_reg       <= 1'b0;
      gecerli_reg    <= 2'b00;
      case (durum)
        BOSTA: begin
          if (kabul) begin
            adres_reg      <= sec_adres;
            yaz_veri_reg   <= sec_veri;
            yaz_reg        <= sec_yaz;
            sahip          <= secim_id;
            son_sahip      <= secim_id;
            bellek_yaz_reg <= sec_yaz && !korumali;
            hata_reg       <= korumali;
            durum          <= ERISIM;
          end
        end
        ERISIM: begin
          if (yaz_reg) begin
            durum <= BOSTA;
          end else if (OKU_GECIKME == 0) begin
            oku_veri_reg[sahip] <= bus.bellek_oku_veri;
            gecerli_reg[sahip]  <= 1'b1;
            durum               <= BOSTA;
          end else begin
            sayac <= SAYAC_BIT'(OKU_GECIKME);
            durum <= BEKLE;
          end
        end
        BEKLE: begin
          sayac <= sayac - 1'b1;
          if (sayac == SAYAC_BIT'(1)) begin
            oku_veri_reg[sahip] <= bus.bellek_oku_veri;
            gecerli_reg[sahip]  <= 1'b1;
            durum               <= BOSTA;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

  assign bus.m0_hazir       = kabul && (secim_id == ISTEKCI_ISLEMCI);
  assign bus.m1_hazir       = kabul && (secim_id == ISTEKCI_YUKLEYICI);
  assign bus.m0_oku_veri    = oku_veri_reg[0];
  assign bus.m1_oku_veri    = oku_veri_reg[1];
  assign bus.m0_oku_gecerli = gecerli_reg[0];
  assign bus.m1_oku_gecerli = gecerli_reg[1];
  assign bus.m1_hata        = hata_reg;
  assign bus.bellek_adres    = adres_reg;
  assign bus.bellek_yaz_veri = yaz_veri_reg;
  assign bus.bellek_yaz      = bellek_yaz_reg;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi: one instance with zero read latency,
// one with OKU_GECIKME=3. Protection expectations follow
// BELLEK_HAKEMI_KORUMA_EN.
module tb_bellek_hakemi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;

`ifdef BELLEK_HAKEMI_KORUMA_EN
  localparam bit KORUMA = 1'b1;
`else
  localparam bit KORUMA = 1'b0;
`endif

  always #5 clk = ~clk;

  bellek_hakemi_if #(.VERI_BIT(32), .ADRES_BIT(32)) bus0 ();
  bellek_hakemi_if #(.VERI_BIT(32), .ADRES_BIT(32)) bus3 ();

  bellek_hakemi #(.OKU_GECIKME(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bellek_hakemi #(.OKU_GECIKME(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Memory models: dut0 returns the inverted address, dut3 a fixed word.
  assign bus0.bellek_oku_veri = ~bus0.bellek_adres;
  assign bus3.bellek_oku_veri = (bus3.bellek_adres == 32'h8000_0020) ? 32'h1234_5678 : 32'h0BAD_0BAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus0.m0_istek = 0; bus0.m0_yaz = 0; bus0.m0_adres = '0; bus0.m0_yaz_veri = '0;
    bus0.m1_istek = 0; bus0.m1_yaz = 0; bus0.m1_adres = '0; bus0.m1_yaz_veri = '0;
    bus3.m0_istek = 0; bus3.m0_yaz = 0; bus3.m0_adres = '0; bus3.m0_yaz_veri = '0;
    bus3.m1_istek = 0; bus3.m1_yaz = 0; bus3.m1_adres = '0; bus3.m1_yaz_veri = '0;

    // Reset with both requesting reads
    bus0.m0_istek = 1; bus0.m0_adres = 32'h0000_0100;
    bus0.m1_istek = 1; bus0.m1_adres = 32'h0000_0200;
    adim(); #1;
    $display("step: reset state");
    chk("rst_hazir", {bus0.m0_hazir, bus0.m1_hazir}, 0);
    chk("rst_bellek_adres", bus0.bellek_adres, 0);
    chk("rst_bellek_yaz", bus0.bellek_yaz, 0);
    chk("rst_gecerli", {bus0.m0_oku_gecerli, bus0.m1_oku_gecerli}, 0);
    chk("rst_hata", bus0.m1_hata, 0);

    rst = 1; #1;
    $display("step: tie after reset");
    chk("tie_m0_hazir", bus0.m0_hazir, 1);
    chk("tie_m1_hazir", bus0.m1_hazir, 0);
    adim(); #1;
    chk("m0_erisim_adres", bus0.bellek_adres, 32'h0000_0100);
    chk("erisim_hazir", {bus0.m0_hazir, bus0.m1_hazir}, 0);
    adim();
    bus0.m0_adres = 32'h0000_0104; #1;
    $display("step: m0 read return, m1 grant");
    chk("m0_gecerli", bus0.m0_oku_gecerli, 1);
    chk("m0_oku_veri", bus0.m0_oku_veri, 32'hFFFF_FEFF);
    chk("alt_m1_hazir", bus0.m1_hazir, 1);
    chk("alt_m0_hazir", bus0.m0_hazir, 0);
    adim(); #1;
    chk("m1_erisim_adres", bus0.bellek_adres, 32'h0000_0200);
    adim(); #1;
    $display("step: m1 read return, m0 grant");
    chk("m1_gecerli", bus0.m1_oku_gecerli, 1);
    chk("m1_oku_veri", bus0.m1_oku_veri, 32'hFFFF_FDFF);
    chk("alt2_m0_hazir", bus0.m0_hazir, 1);
    chk("alt2_m0_gecerli", bus0.m0_oku_gecerli, 0);
    bus0.m1_istek = 0;
    adim();
    bus0.m0_adres = 32'h0000_0108; #1;
    chk("b2b_adres1", bus0.bellek_adres, 32'h0000_0104);
    adim(); #1;
    $display("step: back-to-back m0 reads");
    chk("b2b_gecerli1", bus0.m0_oku_gecerli, 1);
    chk("b2b_veri1", bus0.m0_oku_veri, 32'hFFFF_FEFB);
    chk("b2b_hazir", bus0.m0_hazir, 1);
    adim();
    bus0.m0_istek = 0; #1;
    chk("b2b_adres2", bus0.bellek_adres, 32'h0000_0108);
    chk("b2b_erisim_gec", bus0.m0_oku_gecerli, 0);
    adim(); #1;
    chk("b2b_gecerli2", bus0.m0_oku_gecerli, 1);
    chk("b2b_veri2", bus0.m0_oku_veri, 32'hFFFF_FEF7);

    // m0 write
    $display("step: m0 write 80000010");
    bus0.m0_istek = 1; bus0.m0_yaz = 1; bus0.m0_adres = 32'h8000_0010; bus0.m0_yaz_veri = 32'hDEAD_BEEF; #1;
    chk("wr_hazir", bus0.m0_hazir, 1);
    adim();
    bus0.m0_istek = 0; bus0.m0_yaz = 0; #1;
    chk("wr_yaz", bus0.bellek_yaz, 1);
    chk("wr_adres", bus0.bellek_adres, 32'h8000_0010);
    chk("wr_veri", bus0.bellek_yaz_veri, 32'hDEAD_BEEF);
    adim(); #1;
    chk("wr_yaz_bitti", bus0.bellek_yaz, 0);
    chk("wr_gecerli", {bus0.m0_oku_gecerli, bus0.m1_oku_gecerli}, 0);
    chk("wr_adres_tut", bus0.bellek_adres, 32'h8000_0010);

    // m1 write into protected window
    $display("step: m1 write 80000004");
    bus0.m1_istek = 1; bus0.m1_yaz = 1; bus0.m1_adres = 32'h8000_0004; bus0.m1_yaz_veri = 32'hCAFE_F00D; #1;
    chk("kor_m1_hazir", bus0.m1_hazir, 1);
    adim();
    bus0.m1_istek = 0; bus0.m1_yaz = 0; #1;
    chk("kor_m1_yaz", bus0.bellek_yaz, {31'd0, ~KORUMA});
    chk("kor_m1_hata", bus0.m1_hata, {31'd0, KORUMA});
    adim(); #1;
    chk("kor_hata_bitti", {bus0.m1_hata, bus0.bellek_yaz}, 0);
    $display("step: m0 write 80000004");
    bus0.m0_istek = 1; bus0.m0_yaz = 1; bus0.m0_adres = 32'h8000_0004; bus0.m0_yaz_veri = 32'hCAFE_F00D; #1;
    chk("kor_m0_hazir", bus0.m0_hazir, 1);
    adim();
    bus0.m0_istek = 0; bus0.m0_yaz = 0; #1;
    chk("kor_m0_yaz", bus0.bellek_yaz, 1);
    chk("kor_m0_hata", bus0.m1_hata, 0);
    adim();

    // Latency 3: m1 read
    $display("step: latency-3 m1 read 80000020");
    bus3.m1_istek = 1; bus3.m1_adres = 32'h8000_0020; #1;
    chk("g3_m1_hazir", bus3.m1_hazir, 1);
    adim();
    bus3.m1_istek = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("g3_bekle_gecerli", {bus3.m0_oku_gecerli, bus3.m1_oku_gecerli}, 0);
      adim();
    end
    #1;
    chk("g3_m1_gecerli", bus3.m1_oku_gecerli, 1);
    chk("g3_m1_veri", bus3.m1_oku_veri, 32'h1234_5678);
    chk("g3_m0_gecerli", bus3.m0_oku_gecerli, 0);
    adim(); #1;
    chk("g3_pulse_bitti", bus3.m1_oku_gecerli, 0);
    chk("g3_veri_tut", bus3.m1_oku_veri, 32'h1234_5678);

    // Reset during BEKLE
    $display("step: reset during wait");
    bus3.m0_istek = 1; bus3.m0_adres = 32'h8000_0020; #1;
    chk("rb_m0_hazir", bus3.m0_hazir, 1);
    adim();
    bus3.m0_istek = 0;
    adim();
    rst = 0; #1;
    chk("rb_bellek_adres", bus3.bellek_adres, 0);
    chk("rb_m1_veri", bus3.m1_oku_veri, 0);
    chk("rb_bellek_yaz", bus3.bellek_yaz, 0);
    adim();
    adim();
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rb_gecerli_yok", {bus3.m0_oku_gecerli, bus3.m1_oku_gecerli}, 0);
      adim();
    end
    bus3.m0_istek = 1; bus3.m1_istek = 1; #1;
    $display("step: tie after mid-flight reset");
    chk("rb_tie_m0", bus3.m0_hazir, 1);
    chk("rb_tie_m1", bus3.m1_hazir, 0);
    bus3.m0_istek = 0; bus3.m1_istek = 0;
    adim();
    adim();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
